// File: rtl/uart_tx.sv
// UART transmitter: frames a parallel word as start, LSB-first data, optional parity and one stop bit,
// holding each bit for a latched, clamped number of system clocks.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [4:0]            prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int BW = (DATA_WIDTH > 8) ? 4 : 3;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state_q, state_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [4:0]              presc_q, presc_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    par_en_q, par_en_d;
  logic                    par_bit_q, par_bit_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    last_tick;
  logic [BW-1:0]           next_bit;

  assign last_tick = (cnt_q == presc_q - 5'd1);
  assign next_bit  = bit_q + BW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    presc_d   = presc_q;
    bit_d     = bit_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = tx_q;
    busy_d    = busy_q;

    if (state_q != IDLE) begin
      cnt_d = last_tick ? 5'd0 : cnt_q + 5'd1;
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (DATA_VALID && !busy_q) begin
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = (^P_DATA) ^ PAR_TYP;
          presc_d   = (prescale < 5'd4) ? 5'd4 : prescale;
          cnt_d     = 5'd0;
          bit_d     = '0;
          state_d   = START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (last_tick) begin
          state_d = DATA;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        if (last_tick) begin
          if (bit_q == LAST_BIT) begin
            state_d = par_en_q ? PARITY : STOP;
            tx_d    = par_en_q ? par_bit_q : 1'b1;
          end else begin
            bit_d = next_bit;
            tx_d  = data_q[next_bit];
          end
        end
      end
      PARITY: begin
        if (last_tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        // busy drops together with the return to IDLE so a held request is taken one cycle later
        if (last_tick) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      presc_q   <= 5'd4;
      bit_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frames are checked cycle by cycle against a list-of-bits line model.
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [4:0] prescale = 5'd8;
  logic       TX_OUT;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;

  logic exp_tx[$];
  logic exp_busy[$];
  logic obs_tx[$];
  logic obs_busy[$];

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .prescale(prescale),
    .TX_OUT(TX_OUT), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Line model: list of frame bits, each repeated for the clamped bit time.
  task automatic model_frame(input logic [7:0] d, input logic pe, input logic pt, input int ps);
    logic bits[$];
    int eff;
    int ones;
    eff = (ps < 4) ? 4 : ps;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) bits.push_back(pt ? (ones % 2 == 0) : (ones % 2 == 1));
    bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int r = 0; r < eff; r++) begin
        exp_tx.push_back(bits[k]);
        exp_busy.push_back(1'b1);
      end
    end
  endtask

  task automatic model_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(1'b1);
      exp_busy.push_back(1'b0);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input int ps);
    P_DATA = d;
    PAR_EN = pe;
    PAR_TYP = pt;
    prescale = 5'(ps);
    DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
  endtask

  task automatic capture(input int n);
    obs_tx.delete();
    obs_busy.delete();
    for (int i = 0; i < n; i++) begin
      obs_tx.push_back(TX_OUT);
      obs_busy.push_back(busy);
      @(negedge CLK);
    end
  endtask

  function automatic int busy_cycles();
    int c = 0;
    foreach (obs_busy[i]) c += int'(obs_busy[i]);
    return c;
  endfunction

  task automatic test_reset;
    RST = 1'b1;
    DATA_VALID = 1'b1;
    P_DATA = 8'h55;
    repeat (3) @(negedge CLK);
    tests_run++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hold: tx=%b busy=%b, required tx=1 busy=0", TX_OUT, busy);
    end
    RST = 1'b0;
    DATA_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    tests_run++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: tx=%b busy=%b, required tx=1 busy=0", TX_OUT, busy);
    end
  endtask

  task automatic test_even_parity;
    int mism;
    logic [7:0] pattern;
    exp_tx.delete(); exp_busy.delete();
    model_frame(8'hA5, 1'b1, 1'b0, 8);
    model_idle(1);
    send(8'hA5, 1'b1, 1'b0, 8);
    capture(exp_tx.size());
    mism = 0;
    foreach (exp_tx[i]) if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i]) mism++;
    tests_run++;
    if (mism !== 0) begin
      tests_failed++;
      $display("FAIL even_parity_line: %0d mismatched cycles, required 0", mism);
    end
    tests_run++;
    if (busy_cycles() !== 88) begin
      tests_failed++;
      $display("FAIL even_parity_busy_len: %0d cycles, required 88", busy_cycles());
    end
    pattern = 8'b1010_0101;
    mism = 0;
    for (int b = 0; b < 8; b++) if (obs_tx[8 + 8 * b + 3] !== pattern[7 - b]) mism++;
    tests_run++;
    if (mism !== 0 || obs_tx[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL even_parity_bits: %0d wrong data bits, start=%b, required 0 and start=0", mism, obs_tx[0]);
    end
    tests_run++;
    if (obs_tx[72] !== 1'b0 || obs_tx[79] !== 1'b0 || obs_tx[80] !== 1'b1) begin
      tests_failed++;
      $display("FAIL even_parity_slot: parity=%b stop=%b, required parity=0 stop=1", obs_tx[72], obs_tx[80]);
    end
  endtask

  task automatic test_odd_parity;
    int mism;
    exp_tx.delete(); exp_busy.delete();
    model_frame(8'h07, 1'b1, 1'b1, 8);
    model_idle(1);
    send(8'h07, 1'b1, 1'b1, 8);
    capture(exp_tx.size());
    mism = 0;
    foreach (exp_tx[i]) if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i]) mism++;
    tests_run++;
    if (mism !== 0) begin
      tests_failed++;
      $display("FAIL odd_parity_line: %0d mismatched cycles, required 0", mism);
    end
    tests_run++;
    if (obs_tx[76] !== 1'b0) begin
      tests_failed++;
      $display("FAIL odd_parity_slot: parity=%b, required 0", obs_tx[76]);
    end
  endtask

  task automatic test_no_parity;
    int mism;
    exp_tx.delete(); exp_busy.delete();
    model_frame(8'hFF, 1'b0, 1'b0, 16);
    model_idle(1);
    send(8'hFF, 1'b0, 1'b1, 16);
    capture(exp_tx.size());
    mism = 0;
    foreach (exp_tx[i]) if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i]) mism++;
    tests_run++;
    if (mism !== 0) begin
      tests_failed++;
      $display("FAIL no_parity_line: %0d mismatched cycles, required 0", mism);
    end
    tests_run++;
    if (busy_cycles() !== 160) begin
      tests_failed++;
      $display("FAIL no_parity_busy_len: %0d cycles, required 160", busy_cycles());
    end
  endtask

  task automatic test_random;
    int mism;
    logic [7:0] d;
    logic pe, pt;
    int ps;
    for (int f = 0; f < 8; f++) begin
      d  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      ps = $urandom_range(0, 12);
      exp_tx.delete(); exp_busy.delete();
      model_frame(d, pe, pt, ps);
      model_idle(1);
      send(d, pe, pt, ps);
      capture(exp_tx.size());
      mism = 0;
      foreach (exp_tx[i]) if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i]) mism++;
      tests_run++;
      if (mism !== 0) begin
        tests_failed++;
        $display("FAIL random_frame d=%h pe=%b pt=%b ps=%0d: %0d mismatched cycles, required 0", d, pe, pt, ps, mism);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int mism;
    logic [7:0] d;
    send(8'h5A, 1'b1, 1'b0, 6);
    repeat (6 * 3 + 2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    tests_run++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_frame: tx=%b busy=%b, required tx=1 busy=0", TX_OUT, busy);
    end
    d = 8'($urandom);
    exp_tx.delete(); exp_busy.delete();
    model_frame(d, 1'b0, 1'b0, 6);
    model_idle(2);
    send(d, 1'b0, 1'b0, 6);
    capture(exp_tx.size());
    mism = 0;
    foreach (exp_tx[i]) if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i]) mism++;
    tests_run++;
    if (mism !== 0) begin
      tests_failed++;
      $display("FAIL reset_restart_frame: %0d mismatched cycles, required 0", mism);
    end
  endtask

  task automatic test_back_to_back;
    int mism;
    int len;
    exp_tx.delete(); exp_busy.delete();
    model_frame(8'h81, 1'b1, 1'b0, 5);
    len = exp_tx.size();
    model_idle(1);
    model_frame(8'h81, 1'b1, 1'b0, 5);
    model_idle(1);
    model_frame(8'h81, 1'b1, 1'b0, 5);
    model_idle(1);
    send(8'h81, 1'b1, 1'b0, 5);
    obs_tx.delete(); obs_busy.delete();
    for (int i = 0; i < exp_tx.size(); i++) begin
      obs_tx.push_back(TX_OUT);
      obs_busy.push_back(busy);
      if (i == 10) begin P_DATA = 8'h3C; DATA_VALID = 1'b1; end
      if (i == 11) begin P_DATA = 8'h81; DATA_VALID = 1'b0; end
      if (i == 20) DATA_VALID = 1'b1;
      if (i == 2 * len + 2) DATA_VALID = 1'b0;
      @(negedge CLK);
    end
    DATA_VALID = 1'b0;
    mism = 0;
    foreach (exp_tx[i]) if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i]) mism++;
    tests_run++;
    if (mism !== 0) begin
      tests_failed++;
      $display("FAIL back_to_back_line: %0d mismatched cycles, required 0", mism);
    end
    tests_run++;
    if (obs_tx[len] !== 1'b1 || obs_busy[len] !== 1'b0 || obs_tx[len + 1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL back_to_back_gap: idle tx=%b busy=%b next=%b, required 1 0 0", obs_tx[len], obs_busy[len], obs_tx[len + 1]);
    end
  endtask

  task automatic test_prescale_latch;
    int mism;
    logic [7:0] d;
    d = 8'($urandom);
    exp_tx.delete(); exp_busy.delete();
    model_frame(d, 1'b0, 1'b0, 8);
    model_idle(1);
    send(d, 1'b0, 1'b0, 8);
    obs_tx.delete(); obs_busy.delete();
    for (int i = 0; i < exp_tx.size(); i++) begin
      obs_tx.push_back(TX_OUT);
      obs_busy.push_back(busy);
      if (i == 20) begin prescale = 5'd12; P_DATA = ~d; PAR_EN = 1'b1; PAR_TYP = 1'b1; end
      @(negedge CLK);
    end
    mism = 0;
    foreach (exp_tx[i]) if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i]) mism++;
    tests_run++;
    if (mism !== 0) begin
      tests_failed++;
      $display("FAIL prescale_latched: %0d mismatched cycles, required 0", mism);
    end
    d = 8'($urandom);
    exp_tx.delete(); exp_busy.delete();
    model_frame(d, 1'b1, 1'b1, 2);
    model_idle(1);
    send(d, 1'b1, 1'b1, 2);
    capture(exp_tx.size());
    mism = 0;
    foreach (exp_tx[i]) if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i]) mism++;
    tests_run++;
    if (mism !== 0) begin
      tests_failed++;
      $display("FAIL prescale_clamp_line: %0d mismatched cycles, required 0", mism);
    end
    tests_run++;
    if (busy_cycles() !== 44) begin
      tests_failed++;
      $display("FAIL prescale_clamp_busy_len: %0d cycles, required 44", busy_cycles());
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset;
    test_even_parity;
    test_odd_parity;
    test_no_parity;
    test_random;
    test_reset_mid_frame;
    test_back_to_back;
    test_prescale_latch;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
